spi_reg_slave: RTL and testbench

SPI slave (mode 3: CPOL=1, CPHA=1, MSB first) that bridges an external SPI master to an internal register file.
- Each frame is an 8-bit header (R/W flag plus 7-bit address) followed by a 16-bit data word.
- Write frames produce a one-cycle write strobe into the register file.
- Every frame shifts the addressed register's current contents back out on miso.
- All SPI inputs are oversampled in the clk domain.

---
 rtl/spi_reg_slave.sv | 118 +++++++++++
 tb/tb_spi_reg_slave.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - SPI mode-3 slave bridging a master to a register file.
// Define SPI_BURST_EN to let clocking past the first word continue with auto-incremented addresses.
module spi_reg_slave #(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sck,
   input  logic              mosi,
   output logic              miso,
   input  logic              cs,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] data_out,
   output logic              wr_en
);
   localparam int HDR_BITS   = 1 + ADDR_W;
   localparam int FRAME_BITS = HDR_BITS + DATA_W;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);
   localparam int SH_W       = (DATA_W > HDR_BITS ? DATA_W : HDR_BITS) - 1;
   localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(HDR_BITS - 1);
   localparam logic [CNT_W-1:0] HDR_DONE   = CNT_W'(HDR_BITS);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] FRAME_DONE = CNT_W'(FRAME_BITS);

   logic [SYNC_STAGES-1:0] sck_q, mosi_q, cs_q, fill;
   logic                   sck_prev, cs_prev, armed, active, rd_flag, load_pend;
   logic [CNT_W-1:0]       bit_cnt;
   logic [SH_W-1:0]        rx_sh;
   logic [DATA_W-1:0]      tx_sh;
   logic                   sck_s, mosi_s, cs_s, settled, sck_rise, sck_fall, frame_start;
   logic [HDR_BITS-1:0]    hdr_word;
   logic [DATA_W-1:0]      data_word;
`ifdef SPI_BURST_EN
   logic                   burst_cont;
`endif

   assign sck_s       = sck_q[SYNC_STAGES-1];
   assign mosi_s      = mosi_q[SYNC_STAGES-1];
   assign cs_s        = cs_q[SYNC_STAGES-1];
   assign settled     = fill[SYNC_STAGES-1];
   assign sck_rise    = !sck_prev && sck_s;
   assign sck_fall    = sck_prev && !sck_s;
   // armed needs a real (post-reset) cs-high sample, so a reset mid-frame never resumes that frame
   assign frame_start = armed && cs_prev && !cs_s;
   assign hdr_word    = {rx_sh[ADDR_W-1:0], mosi_s};
   assign data_word   = {rx_sh[DATA_W-2:0], mosi_s};

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_q <= '1; cs_q <= '1; mosi_q <= '0; fill <= '0;
         sck_prev <= 1'b1; cs_prev <= 1'b1;
         armed <= 1'b0; active <= 1'b0; rd_flag <= 1'b0; load_pend <= 1'b0;
         bit_cnt <= '0; rx_sh <= '0; tx_sh <= '0;
         addr <= '0; data_in <= '0; wr_en <= 1'b0; miso <= 1'b0;
`ifdef SPI_BURST_EN
         burst_cont <= 1'b0;
`endif
      end else begin
         sck_q    <= {sck_q[SYNC_STAGES-2:0], sck};
         mosi_q   <= {mosi_q[SYNC_STAGES-2:0], mosi};
         cs_q     <= {cs_q[SYNC_STAGES-2:0], cs};
         fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
         sck_prev <= sck_s;
         cs_prev  <= cs_s;
         wr_en     <= 1'b0;
         load_pend <= 1'b0;
         miso      <= (active && !cs_s) ? tx_sh[DATA_W-1] : 1'b0;
         if (settled && cs_s)
            armed <= 1'b1;

         if (cs_s) begin
            active <= 1'b0;
         end else if (frame_start) begin
            active  <= 1'b1;
            bit_cnt <= '0;
            rx_sh   <= '0;
            tx_sh   <= '0;
            rd_flag <= 1'b0;
`ifdef SPI_BURST_EN
            burst_cont <= 1'b0;
`endif
         end else if (active) begin
            // data_out follows addr, so the read word is captured one cycle after addr updates
            if (load_pend)
               tx_sh <= data_out;
            else if (sck_fall && bit_cnt > HDR_DONE)
               tx_sh <= tx_sh << 1;

            if (sck_rise) begin
               rx_sh <= {rx_sh[SH_W-2:0], mosi_s};
               if (bit_cnt == HDR_LAST) begin
                  addr      <= hdr_word[ADDR_W-1:0];
                  rd_flag   <= hdr_word[ADDR_W];
                  load_pend <= 1'b1;
                  bit_cnt   <= bit_cnt + 1'b1;
               end else if (bit_cnt == FRAME_LAST) begin
                  data_in <= data_word;
                  wr_en   <= !rd_flag;
`ifdef SPI_BURST_EN
                  if (burst_cont)
                     addr <= addr + 1'b1;
                  burst_cont <= 1'b1;
                  load_pend  <= 1'b1;
                  bit_cnt    <= HDR_DONE;
`else
                  bit_cnt <= bit_cnt + 1'b1;
`endif
               end else if (bit_cnt != FRAME_DONE) begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_spi_reg_slave.sv
// tb/tb_spi_reg_slave.sv - scoreboard bench for spi_reg_slave.
module tb_spi_reg_slave;
   logic        clk = 1'b0, rst = 1'b1, sck = 1'b1, mosi = 1'b0, cs = 1'b1;
   logic        miso, wr_en;
   logic [6:0]  addr;
   logic [15:0] data_in, data_out;
   logic [15:0] regs [0:127];
   int          total = 0, bad = 0;

   typedef struct { logic [6:0] a; logic [15:0] d; } wr_t;
   typedef struct { int n; logic [63:0] v; } rx_t;
   wr_t exp_wr[$];
   rx_t exp_rx[$];
   wr_t e_wr;
   rx_t e_rx;
   logic [63:0] rx_v = '0;
   int          rx_n = 0;

   always #1 clk = ~clk;

   spi_reg_slave dut (
      .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .miso(miso), .cs(cs),
      .addr(addr), .data_in(data_in), .data_out(data_out), .wr_en(wr_en)
   );

   assign data_out = regs[addr];
   always @(posedge clk) if (wr_en) regs[addr] <= data_in;

   always @(negedge clk) begin
      if (wr_en) begin
         total++;
         if (exp_wr.size() == 0) begin
            bad++;
            $display("FAIL wr_unexpected addr=%h data_in=%h required=no write", addr, data_in);
         end else begin
            e_wr = exp_wr.pop_front();
            if (addr !== e_wr.a || data_in !== e_wr.d) begin
               bad++;
               $display("FAIL wr_strobe actual=%h/%h required=%h/%h", addr, data_in, e_wr.a, e_wr.d);
            end
         end
      end
   end

   always @(posedge sck) if (cs === 1'b0) begin
      rx_v = {rx_v[62:0], miso};
      rx_n++;
   end

   always @(posedge cs) if (rx_n > 0) begin
      total++;
      if (exp_rx.size() == 0) begin
         bad++;
         $display("FAIL miso_unexpected bits=%0d value=%h", rx_n, rx_v);
      end else begin
         e_rx = exp_rx.pop_front();
         if (e_rx.n >= 0 && (rx_n != e_rx.n || rx_v !== e_rx.v)) begin
            bad++;
            $display("FAIL miso_frame actual=%0d/%h required=%0d/%h", rx_n, rx_v, e_rx.n, e_rx.v);
         end
      end
      rx_n = 0;
      rx_v = '0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic frame(input logic [63:0] bits, input int n, input int rst_at);
      @(negedge clk) cs = 1'b0;
      repeat (20) @(negedge clk);
      for (int i = 0; i < n; i++) begin
         sck  = 1'b0;
         mosi = bits[n-1-i];
         repeat (25) @(negedge clk);
         sck = 1'b1;
         repeat (25) @(negedge clk);
         if (i + 1 == rst_at) begin
            rst = 1'b1;
            @(negedge clk) rst = 1'b0;
            chk("midrst_addr", 32'(addr), 32'h0);
            chk("midrst_data_in", 32'(data_in), 32'h0);
            chk("midrst_wr_en", 32'(wr_en), 32'h0);
            chk("midrst_miso", 32'(miso), 32'h0);
         end
      end
      repeat (20) @(negedge clk);
      cs = 1'b1;
      repeat (40) @(negedge clk);
   endtask

   task automatic push_wr(input logic [6:0] a, input logic [15:0] d);
      wr_t w;
      w.a = a; w.d = d;
      exp_wr.push_back(w);
   endtask

   task automatic push_rx(input int n, input logic [63:0] v);
      rx_t r;
      r.n = n; r.v = v;
      exp_rx.push_back(r);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) regs[i] = 16'(i * 16'h11);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset_addr", 32'(addr), 32'h0);
      chk("reset_data_in", 32'(data_in), 32'h0);
      chk("reset_wr_en", 32'(wr_en), 32'h0);
      chk("reset_miso", 32'(miso), 32'h0);

      push_wr(7'h05, 16'hBEEF);
      push_rx(24, 64'h000055);
      frame(64'h05BEEF, 24, 0);
      chk("t1_reg5", 32'(regs[5]), 32'hBEEF);

      push_rx(24, 64'h00BEEF);
      frame(64'h850000, 24, 0);
      chk("t2_addr", 32'(addr), 32'h05);
      chk("t2_data_in", 32'(data_in), 32'h0000);

      push_rx(12, 64'h0);
      frame(64'h0A1, 12, 0);
      chk("t3_data_in", 32'(data_in), 32'h0000);
      chk("t3_reg10", 32'(regs[10]), 32'h00AA);
      chk("t3_addr", 32'(addr), 32'h0A);

      push_rx(24, 64'h0);
      frame(64'h041357, 24, 10);
      chk("t4_addr_after_abandon", 32'(addr), 32'h0);
      chk("t4_data_in_after_abandon", 32'(data_in), 32'h0);
      chk("t4_reg4", 32'(regs[4]), 32'h0044);
      push_wr(7'h03, 16'hCAFE);
      push_rx(24, 64'h000033);
      frame(64'h03CAFE, 24, 0);
      chk("t4_reg3", 32'(regs[3]), 32'hCAFE);

      push_wr(7'h07, 16'hABCD);
      push_rx(30, 64'h1DC0);
      frame((64'h07ABCD << 6) | 64'h3F, 30, 0);
      chk("t5_addr", 32'(addr), 32'h07);
      chk("t5_data_in", 32'(data_in), 32'hABCD);
      chk("t5_reg7", 32'(regs[7]), 32'hABCD);

`ifdef SPI_BURST_EN
      push_wr(7'h7F, 16'h1111);
      push_wr(7'h00, 16'h2222);
      push_rx(-1, 64'h0);
      frame(64'h7F11112222, 40, 0);
      chk("t6_reg127", 32'(regs[127]), 32'h1111);
      chk("t6_reg0", 32'(regs[0]), 32'h2222);
`endif

      repeat (10) @(negedge clk);
      chk("pending_writes", 32'(exp_wr.size()), 32'h0);
      chk("pending_frames", 32'(exp_rx.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
